// File: rtl/cic_interp_sequencer_if.sv
// Upstream sample stream into the CIC interpolator sequencer.
// Valid/ready handshake; a sample moves on an edge with both high.
interface cic_interp_sequencer_if #(
  parameter int ISZ = 16
);
  logic signed [ISZ-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/cic_interp_sequencer.sv
// Output-rate sequencer for the CIC interpolator: 1-in-R strobe,
// zero stuffing on underrun, zero flush of the chain on stop.
module cic_interp_sequencer #(
  parameter int ISZ           = 16,
  parameter int RSZ           = 8,
  parameter int FLUSH_SAMPLES = 4,
  parameter int CNT_SZ        = 16
) (
  input  logic                  out_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RSZ-1:0]        ratio,
  cic_interp_sequencer_if.slave s,
  output logic                  cic_reset,
  output logic                  cic_in_clk,
  output logic signed [ISZ-1:0] cic_in,
  output logic                  running,
  output logic                  underrun,
  output logic [CNT_SZ-1:0]     underrun_cnt
);

  localparam int PW = RSZ + 1;
  localparam int FW = $clog2(FLUSH_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ratio_q;
  logic [PW-1:0]         r_phase;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_cic_reset;
  logic                  r_strobe;
  logic signed [ISZ-1:0] r_cic_in;
  logic                  r_underrun;
  logic [CNT_SZ-1:0]     r_cnt;

  logic                  w_slot;
  logic                  w_wrap;
  logic [PW-1:0]         w_phase_nxt;
  logic [PW-1:0]         w_eff_ratio;
  logic                  w_flush_done;

  assign w_slot       = (r_phase == '0);
  assign w_wrap       = (r_phase == r_ratio_q - PW'(1));
  assign w_phase_nxt  = w_wrap ? '0 : r_phase + PW'(1);
  assign w_eff_ratio  = (ratio == '0) ? PW'(1 << RSZ)
                                      : {1'b0, ratio};
  assign w_flush_done = (r_flush_cnt == FW'(FLUSH_SAMPLES));

  // stop has priority over the handshake at a slot edge
  assign s.s_ready    = (r_state == S_RUN) && w_slot && enable;

  assign cic_reset    = r_cic_reset;
  assign cic_in_clk   = r_strobe;
  assign cic_in       = r_cic_in;
  assign running      = (r_state != S_IDLE);
  assign underrun     = r_underrun;
  assign underrun_cnt = r_cnt;

  // sequencer FSM, phase counter and all registered outputs
  always_ff @(posedge out_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ratio_q   <= '0;
      r_phase     <= '0;
      r_flush_cnt <= '0;
      r_cic_reset <= 1'b1;
      r_strobe    <= 1'b0;
      r_cic_in    <= '0;
      r_underrun  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cic_reset <= 1'b1;
          r_phase     <= '0;
          if (enable) begin
            r_state     <= S_PRIME;
            r_ratio_q   <= w_eff_ratio;
            r_cic_reset <= 1'b0;
          end
        end
        S_PRIME: begin
          r_phase <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_phase <= w_phase_nxt;
          if (w_slot) begin
            r_strobe <= 1'b1;
            if (!enable) begin
              r_cic_in    <= '0;
              r_flush_cnt <= FW'(1);
              r_state     <= S_FLUSH;
            end else if (s.s_valid) begin
              r_cic_in <= s.s_data;
            end else begin
              r_cic_in   <= '0;
              r_underrun <= 1'b1;
              if (!(&r_cnt)) r_cnt <= r_cnt + CNT_SZ'(1);
            end
          end
        end
        S_FLUSH: begin
          r_phase <= w_phase_nxt;
          if (w_slot) begin
            if (w_flush_done) begin
              r_state     <= S_IDLE;
              r_cic_reset <= 1'b1;
              r_phase     <= '0;
            end else begin
              r_strobe    <= 1'b1;
              r_cic_in    <= '0;
              r_flush_cnt <= r_flush_cnt + FW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
